fb_port_arbiter: RTL and testbench

FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

---
 rtl/fb_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_fb_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - single-port frame buffer arbiter: camera write FIFO vs filter reads
module fb_port_arbiter #(
    parameter int IMG_WIDTH   = 160,
    parameter int IMG_HEIGHT  = 120,
    parameter int ADDR_WIDTH  = $clog2(IMG_WIDTH*IMG_HEIGHT),
    parameter int WFIFO_DEPTH = 8,
    parameter int RD_LATENCY  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [15:0]           wr_data,
    output logic                  wr_ready,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_grant,
    output logic                  rd_valid,
    output logic [15:0]           rd_data,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    output logic                  wfifo_overflow,
    output logic                  addr_err
);

    localparam int PW       = $clog2(WFIFO_DEPTH);
    localparam int CW       = $clog2(WFIFO_DEPTH + 1);
    localparam int NPIX     = IMG_WIDTH * IMG_HEIGHT;
    localparam int NPIX_M1  = NPIX - 1;
    localparam logic [ADDR_WIDTH:0]   NPIX_W    = NPIX[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = NPIX_M1[ADDR_WIDTH-1:0];
    localparam logic [CW-1:0] CNT_FULL = CW'(WFIFO_DEPTH);
    localparam logic [CW-1:0] CNT_HI   = CW'(WFIFO_DEPTH - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(WFIFO_DEPTH / 2);

    typedef enum logic [1:0] {
        RD_PRI   = 2'd0,
        WR_DRAIN = 2'd1,
        FORCE_WR = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             count_q, count_d;
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [RD_LATENCY-1:0]     pipe_q, pipe_d;
    logic                      overflow_q, overflow_d;
    logic                      addr_err_q, addr_err_d;
    logic [ADDR_WIDTH+15:0]    fifo_q [WFIFO_DEPTH];

    logic                      full, empty, addr_ok, push, pop;
    logic [ADDR_WIDTH-1:0]     head_addr;
    logic [15:0]               head_data;

    always_comb begin
        full                   = (count_q == CNT_FULL);
        empty                  = (count_q == '0);
        wr_ready               = !full;
        addr_ok                = ({1'b0, wr_addr} < NPIX_W);
        push                   = wr_req && wr_ready && addr_ok;
        {head_addr, head_data} = fifo_q[rd_ptr_q];
    end

    // Issue decode: the read side is gated by reset so a held rd_req cannot leak out during reset.
    always_comb begin
        rd_grant  = 1'b0;
        pop       = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q != FORCE_WR && rd_req && reset) begin
            rd_grant = 1'b1;
            mem_en   = 1'b1;
            mem_addr = ({1'b0, rd_addr} >= NPIX_W) ? LAST_ADDR : rd_addr;
        end else if (!empty) begin
            pop       = 1'b1;
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = head_addr;
            mem_wdata = head_data;
        end
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        pipe_d     = RD_LATENCY'({pipe_q, rd_grant});
        overflow_d = overflow_q || (wr_req && !wr_ready);
        addr_err_d = addr_err_q || (wr_req && wr_ready && !addr_ok);
    end

    // Drain hysteresis: forced write near full, then stay draining until half empty.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_PRI:   if (count_q >= CNT_HI) state_d = FORCE_WR;
            FORCE_WR: state_d = WR_DRAIN;
            WR_DRAIN: begin
                if (count_q >= CNT_HI) begin
                    state_d = FORCE_WR;
                end else if (count_q <= CNT_HALF) begin
                    state_d = RD_PRI;
                end
            end
            default:  state_d = RD_PRI;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RD_PRI;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pipe_q     <= '0;
            overflow_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pipe_q     <= pipe_d;
            overflow_q <= overflow_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {wr_addr, wr_data};
        end
    end

    always_comb begin
        rd_valid       = pipe_q[RD_LATENCY-1];
        rd_data        = rd_valid ? mem_rdata : 16'h0000;
        wfifo_overflow = overflow_q;
        addr_err       = addr_err_q;
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb/tb_fb_port_arbiter.sv - directed bench for fb_port_arbiter
module tb_fb_port_arbiter;

    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [15:0]   wr_data = '0;
    logic          wr_ready;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_grant, rd_valid;
    logic [15:0]   rd_data;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata = '0;
    logic          wfifo_overflow, addr_err;

    int errors = 0;
    int checks = 0;

    fb_port_arbiter dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .wfifo_overflow(wfifo_overflow), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle read returning address ^ 5A5A.
    always @(posedge clk) begin
        mem_rdata <= (mem_en && !mem_we) ? ({1'b0, mem_addr} ^ 16'h5A5A) : 16'h0000;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; rd_req = 1'b1; rd_addr = 15'd100; wr_req = 1'b1; wr_addr = 15'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
            errors++; $display("FAIL reset_mem: en=%b we=%b expected 0 0", mem_en, mem_we);
        end
        checks++;
        if (rd_grant !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 16'h0) begin
            errors++; $display("FAIL reset_rd: grant=%b valid=%b data=%h expected 0 0 0", rd_grant, rd_valid, rd_data);
        end
        checks++;
        if (wr_ready !== 1'b1 || wfifo_overflow !== 1'b0 || addr_err !== 1'b0) begin
            errors++; $display("FAIL reset_flags: ready=%b ovf=%b aerr=%b expected 1 0 0", wr_ready, wfifo_overflow, addr_err);
        end
        next_cycle();
        reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0) begin
            errors++; $display("FAIL reset_release_idle: mem_en=%b expected 0", mem_en);
        end
        next_cycle();
    endtask

    task automatic test_read_stream();
        logic [AW-1:0] addrs [5];
        addrs = '{15'd100, 15'd100, 15'd100, 15'd200, 15'd201};
        for (int i = 0; i < 6; i++) begin
            rd_req  = (i < 5);
            rd_addr = (i < 5) ? addrs[i] : 15'd0;
            @(negedge clk);
            if (i < 5) begin
                checks++;
                if (rd_grant !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== addrs[i]) begin
                    errors++; $display("FAIL rd_issue[%0d]: grant=%b en=%b we=%b addr=%0d expected 1 1 0 %0d",
                                       i, rd_grant, mem_en, mem_we, mem_addr, addrs[i]);
                end
            end
            if (i > 0) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== ({1'b0, addrs[i-1]} ^ 16'h5A5A)) begin
                    errors++; $display("FAIL rd_return[%0d]: valid=%b data=%h expected 1 %h",
                                       i, rd_valid, rd_data, {1'b0, addrs[i-1]} ^ 16'h5A5A);
                end
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || mem_en !== 1'b0 || mem_addr !== 15'd0 || mem_wdata !== 16'h0) begin
            errors++; $display("FAIL rd_idle: valid=%b en=%b addr=%0d wdata=%h expected 0 0 0 0",
                               rd_valid, mem_en, mem_addr, mem_wdata);
        end
        next_cycle();
    endtask

    task automatic test_writes();
        for (int i = 0; i < 5; i++) begin
            wr_req  = (i < 3);
            wr_addr = AW'(5 + i);
            wr_data = 16'hC000 | 16'(5 + i);
            @(negedge clk);
            checks++;
            if (i == 0 || i == 4) begin
                if (mem_en !== 1'b0) begin
                    errors++; $display("FAIL wr_idle[%0d]: mem_en=%b expected 0", i, mem_en);
                end
            end else if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(4 + i) ||
                         mem_wdata !== (16'hC000 | 16'(4 + i))) begin
                errors++; $display("FAIL wr_issue[%0d]: en=%b we=%b addr=%0d data=%h expected 1 1 %0d %h",
                                   i, mem_en, mem_we, mem_addr, mem_wdata, 4 + i, 16'hC000 | 16'(4 + i));
            end
            next_cycle();
        end
    endtask

    task automatic test_force_wr();
        rd_addr = 15'd300;
        for (int i = 0; i < 17; i++) begin
            wr_req  = (i < 7);
            wr_addr = AW'(10 + i);
            wr_data = 16'hB000 + 16'(i);
            rd_req  = (i < 10);
            @(negedge clk);
            if (i <= 7) begin
                checks++;
                if (rd_grant !== 1'b1 || mem_we !== 1'b0) begin
                    errors++; $display("FAIL fw_read[%0d]: grant=%b we=%b expected 1 0", i, rd_grant, mem_we);
                end
            end else if (i == 8) begin
                checks++;
                if (rd_grant !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 15'd10 || mem_wdata !== 16'hB000) begin
                    errors++; $display("FAIL fw_force: grant=%b we=%b addr=%0d data=%h expected 0 1 10 b000",
                                       rd_grant, mem_we, mem_addr, mem_wdata);
                end
            end else if (i == 9) begin
                checks++;
                if (rd_grant !== 1'b1 || rd_valid !== 1'b0) begin
                    errors++; $display("FAIL fw_regrant: grant=%b valid=%b expected 1 0", rd_grant, rd_valid);
                end
            end else if (i <= 15) begin
                checks++;
                if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(1 + i) ||
                    mem_wdata !== (16'hB000 + 16'(i - 9))) begin
                    errors++; $display("FAIL fw_drain[%0d]: en=%b we=%b addr=%0d data=%h expected 1 1 %0d %h",
                                       i, mem_en, mem_we, mem_addr, mem_wdata, 1 + i, 16'hB000 + 16'(i - 9));
                end
            end else begin
                checks++;
                if (mem_en !== 1'b0) begin
                    errors++; $display("FAIL fw_empty: mem_en=%b expected 0", mem_en);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_overflow();
        rd_addr = 15'd400;
        for (int i = 0; i < 18; i++) begin
            wr_req  = (i <= 8);
            wr_addr = (i < 8) ? AW'(20 + i) : 15'd99;
            wr_data = 16'hA000 + 16'(i);
            rd_req  = (i < 9);
            @(negedge clk);
            if (i == 8) begin
                checks++;
                if (wr_ready !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 15'd20) begin
                    errors++; $display("FAIL ovf_full: ready=%b we=%b addr=%0d expected 0 1 20", wr_ready, mem_we, mem_addr);
                end
            end else if (i >= 9 && i <= 15) begin
                checks++;
                if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(12 + i)) begin
                    errors++; $display("FAIL ovf_drain[%0d]: en=%b we=%b addr=%0d expected 1 1 %0d",
                                       i, mem_en, mem_we, mem_addr, 12 + i);
                end
                if (i == 9) begin
                    checks++;
                    if (wfifo_overflow !== 1'b1 || wr_ready !== 1'b1) begin
                        errors++; $display("FAIL ovf_flag: ovf=%b ready=%b expected 1 1", wfifo_overflow, wr_ready);
                    end
                end
            end else if (i == 16) begin
                checks++;
                if (mem_en !== 1'b0) begin
                    errors++; $display("FAIL ovf_dropped: mem_en=%b addr=%0d expected 0", mem_en, mem_addr);
                end
            end else if (i == 17) begin
                checks++;
                if (wfifo_overflow !== 1'b1 || addr_err !== 1'b0) begin
                    errors++; $display("FAIL ovf_sticky: ovf=%b aerr=%b expected 1 0", wfifo_overflow, addr_err);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_addr_range();
        wr_req = 1'b1; wr_addr = 15'd19200; wr_data = 16'hDEAD; rd_req = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1 || addr_err !== 1'b0) begin
            errors++; $display("FAIL aerr_pre: ready=%b aerr=%b expected 1 0", wr_ready, addr_err);
        end
        next_cycle();
        wr_req = 1'b0; rd_req = 1'b1; rd_addr = 15'd19500;
        @(negedge clk);
        checks++;
        if (addr_err !== 1'b1) begin
            errors++; $display("FAIL aerr_set: aerr=%b expected 1", addr_err);
        end
        checks++;
        if (rd_grant !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 15'd19199) begin
            errors++; $display("FAIL rd_clamp: grant=%b we=%b addr=%0d expected 1 0 19199", rd_grant, mem_we, mem_addr);
        end
        next_cycle();
        rd_req = 1'b0; wr_req = 1'b1; wr_addr = 15'd19199; wr_data = 16'h1234;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0) begin
            errors++; $display("FAIL aerr_discard: mem_en=%b addr=%0d expected 0", mem_en, mem_addr);
        end
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h10A5) begin
            errors++; $display("FAIL rd_clamp_data: valid=%b data=%h expected 1 10a5", rd_valid, rd_data);
        end
        next_cycle();
        wr_req = 1'b0; rd_req = 1'b1; rd_addr = 15'd19199;
        @(negedge clk);
        checks++;
        if (rd_grant !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 15'd19199) begin
            errors++; $display("FAIL rd_last: grant=%b we=%b addr=%0d expected 1 0 19199", rd_grant, mem_we, mem_addr);
        end
        next_cycle();
        rd_req = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 15'd19199 || mem_wdata !== 16'h1234) begin
            errors++; $display("FAIL wr_last: we=%b addr=%0d data=%h expected 1 19199 1234", mem_we, mem_addr, mem_wdata);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            rd_req = 1'b1; rd_addr = AW'(50 + i);
            wr_req = 1'b1; wr_addr = AW'(40 + i); wr_data = 16'h7000 + 16'(i);
            next_cycle();
        end
        reset = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 16'h0) begin
            errors++; $display("FAIL mid_reset_out: en=%b valid=%b data=%h expected 0 0 0", mem_en, rd_valid, rd_data);
        end
        checks++;
        if (wr_ready !== 1'b1 || wfifo_overflow !== 1'b0 || addr_err !== 1'b0) begin
            errors++; $display("FAIL mid_reset_flags: ready=%b ovf=%b aerr=%b expected 1 0 0", wr_ready, wfifo_overflow, addr_err);
        end
        next_cycle();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (mem_en !== 1'b0 || rd_valid !== 1'b0) begin
                errors++; $display("FAIL post_reset[%0d]: en=%b valid=%b expected 0 0", i, mem_en, rd_valid);
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_read_stream();
        test_writes();
        test_force_wr();
        test_overflow();
        test_addr_range();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
